// File: rtl/motor_ramp_scheduler_if.sv
// Command handshake for motor_ramp_scheduler: one (motor, direction, duty) target per transfer.
// Transfer happens on a rising edge where cmd_valid and cmd_ready are both high.
interface motor_ramp_scheduler_if #(
    parameter int unsigned DUTY_W = 10
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_motor;
    logic              cmd_dir;
    logic [DUTY_W-1:0] cmd_duty;

    modport master (
        output cmd_valid,
        output cmd_motor,
        output cmd_dir,
        output cmd_duty,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_motor,
        input  cmd_dir,
        input  cmd_duty,
        output cmd_ready
    );
endinterface

// File: rtl/motor_ramp_scheduler.sv
// Per-motor duty ramp scheduler with brake-to-zero and dead-time before any direction reversal.
// Define MOTOR_WATCHDOG_EN to add a per-motor command watchdog and the wdt_trip output.
module motor_ramp_scheduler #(
    parameter int unsigned NUM_MOTORS     = 4,
    parameter int unsigned DUTY_W         = 10,
    parameter int unsigned STEP           = 8,
    parameter int unsigned TICK_DIV       = 50000,
    parameter int unsigned DEADTIME_TICKS = 20
`ifdef MOTOR_WATCHDOG_EN
    , parameter int unsigned WDT_TICKS    = 500
`endif
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    motor_ramp_scheduler_if.slave        cmd,
    input  logic                         stop_all,
    output logic [NUM_MOTORS-1:0]        motor_en,
    output logic [NUM_MOTORS-1:0]        motor_dir,
    output logic [NUM_MOTORS*DUTY_W-1:0] motor_duty,
`ifdef MOTOR_WATCHDOG_EN
    output logic [NUM_MOTORS-1:0]        wdt_trip,
`endif
    output logic                         busy
);

    localparam int unsigned IDX_W  = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
    localparam int unsigned TCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DCNT_W = ($clog2(DEADTIME_TICKS + 1) > 0) ?
                                     $clog2(DEADTIME_TICKS + 1) : 1;

    localparam logic [TCNT_W-1:0] TICK_LAST = TCNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_MOTORS - 1);
    localparam logic [DCNT_W-1:0] DEAD_N    = DCNT_W'(DEADTIME_TICKS);
    localparam logic [DUTY_W:0]   STEP_X    = (DUTY_W + 1)'(STEP);

`ifdef MOTOR_WATCHDOG_EN
    localparam int unsigned       WCNT_W    = ($clog2(WDT_TICKS + 1) > 0) ?
                                              $clog2(WDT_TICKS + 1) : 1;
    localparam logic [WCNT_W-1:0] WDT_LAST  = WCNT_W'(WDT_TICKS - 1);
`endif

    typedef enum logic [1:0] {StIdle, StRun, StBrake, StDead} mstate_e;

    logic [TCNT_W-1:0]     tick_cnt_q;
    logic                  sweep_active_q;
    logic [IDX_W-1:0]      sweep_idx_q;
    mstate_e               st_q       [NUM_MOTORS];
    logic [DUTY_W-1:0]     duty_q     [NUM_MOTORS];
    logic [DUTY_W-1:0]     tgt_duty_q [NUM_MOTORS];
    logic [DCNT_W-1:0]     dead_cnt_q [NUM_MOTORS];
    logic [NUM_MOTORS-1:0] tgt_dir_q;
`ifdef MOTOR_WATCHDOG_EN
    logic [WCNT_W-1:0]     wdt_cnt_q  [NUM_MOTORS];
`endif

    logic tick;
    logic cmd_accept;

    assign tick          = (tick_cnt_q == TICK_LAST) && !stop_all;
    assign cmd.cmd_ready = !sweep_active_q && !stop_all;
    assign cmd_accept    = cmd.cmd_valid && cmd.cmd_ready;

    // One STEP toward tgt, computed one bit wider so full scale never wraps.
    function automatic logic [DUTY_W-1:0] ramp_to(input logic [DUTY_W-1:0] cur,
                                                  input logic [DUTY_W-1:0] tgt);
        logic [DUTY_W:0] cur_x;
        logic [DUTY_W:0] tgt_x;
        logic [DUTY_W:0] up_x;
        logic [DUTY_W:0] dn_x;
        cur_x = {1'b0, cur};
        tgt_x = {1'b0, tgt};
        up_x  = cur_x + STEP_X;
        dn_x  = cur_x - STEP_X;
        if (cur_x < tgt_x) begin
            return (up_x >= tgt_x) ? tgt : up_x[DUTY_W-1:0];
        end else if (cur_x > tgt_x) begin
            return (cur_x < tgt_x + STEP_X) ? tgt : dn_x[DUTY_W-1:0];
        end
        return cur;
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            tick_cnt_q     <= '0;
            sweep_active_q <= 1'b0;
            sweep_idx_q    <= '0;
            motor_en       <= '0;
            motor_dir      <= '0;
            tgt_dir_q      <= '0;
            for (int i = 0; i < NUM_MOTORS; i++) begin
                st_q[i]       <= StIdle;
                duty_q[i]     <= '0;
                tgt_duty_q[i] <= '0;
                dead_cnt_q[i] <= '0;
`ifdef MOTOR_WATCHDOG_EN
                wdt_cnt_q[i]  <= '0;
`endif
            end
`ifdef MOTOR_WATCHDOG_EN
            wdt_trip       <= '0;
`endif
        end else if (stop_all) begin
            // Hard stop: directions are kept so the drivers see no spurious flip.
            tick_cnt_q     <= '0;
            sweep_active_q <= 1'b0;
            sweep_idx_q    <= '0;
            motor_en       <= '0;
            tgt_dir_q      <= '0;
            for (int i = 0; i < NUM_MOTORS; i++) begin
                st_q[i]       <= StIdle;
                duty_q[i]     <= '0;
                tgt_duty_q[i] <= '0;
                dead_cnt_q[i] <= '0;
`ifdef MOTOR_WATCHDOG_EN
                wdt_cnt_q[i]  <= '0;
`endif
            end
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TCNT_W'(1);

            if (tick) begin
                sweep_active_q <= 1'b1;
                sweep_idx_q    <= '0;
            end else if (sweep_active_q) begin
                if (sweep_idx_q == IDX_LAST) begin
                    sweep_active_q <= 1'b0;
                end else begin
                    sweep_idx_q <= sweep_idx_q + IDX_W'(1);
                end
            end

            for (int i = 0; i < NUM_MOTORS; i++) begin
                // Indices >= NUM_MOTORS match no channel and are dropped here.
                if (cmd_accept && cmd.cmd_motor == 3'(i)) begin
                    tgt_dir_q[i]  <= cmd.cmd_dir;
                    tgt_duty_q[i] <= cmd.cmd_duty;
`ifdef MOTOR_WATCHDOG_EN
                    wdt_cnt_q[i]  <= '0;
                    wdt_trip[i]   <= 1'b0;
                end else if (tick && tgt_duty_q[i] != '0) begin
                    if (wdt_cnt_q[i] == WDT_LAST) begin
                        tgt_duty_q[i] <= '0;
                        wdt_trip[i]   <= 1'b1;
                        wdt_cnt_q[i]  <= '0;
                    end else begin
                        wdt_cnt_q[i] <= wdt_cnt_q[i] + WCNT_W'(1);
                    end
`endif
                end

                if (sweep_active_q && sweep_idx_q == IDX_W'(i)) begin
                    unique case (st_q[i])
                        StIdle: begin
                            if (tgt_duty_q[i] != '0) begin
                                motor_dir[i] <= tgt_dir_q[i];
                                motor_en[i]  <= 1'b1;
                                duty_q[i]    <= ramp_to('0, tgt_duty_q[i]);
                                st_q[i]      <= StRun;
                            end
                        end
                        StRun: begin
                            if (tgt_dir_q[i] != motor_dir[i]) begin
                                duty_q[i] <= ramp_to(duty_q[i], '0);
                                if (ramp_to(duty_q[i], '0) == '0) begin
                                    motor_en[i]   <= 1'b0;
                                    dead_cnt_q[i] <= '0;
                                    st_q[i]       <= StDead;
                                end else begin
                                    st_q[i] <= StBrake;
                                end
                            end else begin
                                duty_q[i] <= ramp_to(duty_q[i], tgt_duty_q[i]);
                                if (tgt_duty_q[i] == '0 && ramp_to(duty_q[i], '0) == '0) begin
                                    motor_en[i] <= 1'b0;
                                    st_q[i]     <= StIdle;
                                end
                            end
                        end
                        StBrake: begin
                            duty_q[i] <= ramp_to(duty_q[i], '0);
                            if (ramp_to(duty_q[i], '0) == '0) begin
                                motor_en[i]   <= 1'b0;
                                dead_cnt_q[i] <= '0;
                                st_q[i]       <= StDead;
                            end
                        end
                        StDead: begin
                            if (dead_cnt_q[i] + DCNT_W'(1) >= DEAD_N) begin
                                motor_dir[i] <= tgt_dir_q[i];
                                if (tgt_duty_q[i] != '0) begin
                                    motor_en[i] <= 1'b1;
                                    duty_q[i]   <= ramp_to('0, tgt_duty_q[i]);
                                    st_q[i]     <= StRun;
                                end else begin
                                    st_q[i] <= StIdle;
                                end
                            end else begin
                                dead_cnt_q[i] <= dead_cnt_q[i] + DCNT_W'(1);
                            end
                        end
                        default: st_q[i] <= StIdle;
                    endcase
                end
            end
        end
    end

    always_comb begin
        motor_duty = '0;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            motor_duty[i*DUTY_W +: DUTY_W] = duty_q[i];
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            if (duty_q[i] != tgt_duty_q[i] || st_q[i] == StBrake || st_q[i] == StDead) begin
                busy = 1'b1;
            end
        end
    end

endmodule

// File: doc/motor_ramp_scheduler.md
Name: motor_ramp_scheduler

Overview:
- Per-motor command scheduler that drives the enable, direction and duty inputs of up to NUM_MOTORS downstream motor_controller PWM instances.
- Accepts target (direction, duty) commands over a valid/ready port and stores them per motor.
- On each ramp tick, one shared ramp engine sweeps all motors in turn and moves each motor's duty toward its target by at most STEP.
- Enforces brake-to-zero plus a dead-time before any direction reversal, so no motor is ever reversed under load.

Parameters:
NUM_MOTORS, 4, number of motor channels (1..8)
DUTY_W, 10, duty width; full scale = 2^DUTY_W-1
STEP, 8, maximum duty change per motor per tick
TICK_DIV, 50000, clocks per ramp tick (1 ms at 50 MHz)
DEADTIME_TICKS, 20, ticks held disabled at zero duty before a direction flip
WDT_TICKS, 500, watchdog timeout in ticks (used only with the optional feature)

Ports:
CLOCK_50  in  1  system clock; all logic on rising edge
reset  in  1  synchronous active-high reset
cmd_valid  in  1  command strobe
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_motor  in  3  motor index; indices >= NUM_MOTORS are accepted and dropped
cmd_dir  in  1  requested direction
cmd_duty  in  DUTY_W  requested duty
stop_all  in  1  emergency stop, level sensitive
motor_en  out  NUM_MOTORS  per-motor enable
motor_dir  out  NUM_MOTORS  per-motor direction
motor_duty  out  NUM_MOTORS*DUTY_W  packed duty; motor i occupies bits [i*DUTY_W +: DUTY_W]
busy  out  1  high while any motor has duty != target or is in BRAKE/DEAD

Behaviour:
- Reset values:
  - All outputs 0 except cmd_ready=1.
  - Tick counter 0; all targets 0; all motor FSMs IDLE; sweep index 0.
- Tick and sweep:
  - Tick counter counts 0..TICK_DIV-1 and pulses tick for one cycle at wrap.
  - tick starts a sweep: cycles 1..NUM_MOTORS after tick service motor 0..NUM_MOTORS-1, one per cycle.
  - cmd_ready=0 during sweep cycles and 1 otherwise.
- Commands:
  - An accepted command writes tgt_dir/tgt_duty[cmd_motor] on the next edge.
  - Outputs change only when that motor is serviced in a sweep.
  - Last accepted write wins.
- Per-motor FSM, evaluated when the motor is serviced:
  - IDLE (en=0, duty=0): if tgt_duty != 0, load dir=tgt_dir, go RUN and apply one ramp step in the same service.
  - RUN (en=1):
    - If tgt_dir != dir and duty > 0: go BRAKE and step duty down.
    - Otherwise ramp toward target: up = min(duty+STEP, tgt); down = max(duty-STEP, tgt).
    - Arithmetic is DUTY_W+1 bits with saturation; no wrap at full scale (e.g. 1016 -> 1023, never 0).
    - If duty reaches 0 and tgt_duty == 0: go IDLE, en=0.
  - BRAKE (en=1): step down toward 0. At 0, en=0, clear dead counter, go DEAD.
  - DEAD (en=0, duty=0): count serviced ticks. At DEADTIME_TICKS, dir=tgt_dir; go RUN if tgt_duty != 0, else IDLE.
  - A new command reverting the direction during BRAKE is honoured only after DEAD completes; a completed BRAKE always passes through DEAD.
- stop_all (has priority over commands and the sweep):
  - Takes effect on the next edge: all duty=0, en=0, targets=0, FSMs to IDLE, dir outputs retained.
  - While asserted: cmd_ready=0 and the tick counter is held at 0.
- Reset mid-sweep aborts the sweep; the next sweep starts at motor 0.
- busy is combinational from the registered state.

Optional Feature:
- Macro: MOTOR_WATCHDOG_EN.
- Defined:
  - Each motor keeps a tick count since its last accepted command.
  - At WDT_TICKS the motor's tgt_duty is forced to 0 and it ramps down normally; no hard cut.
  - Output wdt_trip [NUM_MOTORS] is a sticky flag, cleared by a new command to that motor or by reset.
- Undefined: no watchdog logic and no wdt_trip port. Targets persist indefinitely.

Test Plan:
- Bench uses TICK_DIV=4, DEADTIME_TICKS=2.
1. Reset -> motor_en=0, motor_duty=0, cmd_ready=1, busy=0.
2. Cmd motor0 dir=1 duty=20 -> after 1st servicing duty 8, then 16, then 20 and held; en0=1, dir0=1; busy falls after reaching 20.
3. Motor0 at duty 20 dir=1, cmd dir=0 duty=8:
   - duty steps 12, 4, 0 (BRAKE).
   - en0=0 for 2 ticks (DEAD), dir0 becomes 0.
   - duty steps to 8.
4. Cmd motor1 duty=1023 with STEP=8 -> duty saturates 1016 -> 1023 with no wrap; cmd_motor=5 with NUM_MOTORS=4 -> accepted, no state change.
5. stop_all pulsed mid-ramp on motors 0 and 2 -> next edge: all duty 0, en 0, cmd_ready=0 while asserted. After release, motors stay IDLE until new commands.
6. MOTOR_WATCHDOG_EN, WDT_TICKS=3: motor0 at duty 16 with no further commands -> after 3 ticks wdt_trip[0]=1, duty ramps 8, 0 and goes IDLE; a new command clears wdt_trip[0].
